// File: rtl/banco_mem_pkg.sv
// Shared definitions for the parametrised data-memory bank of the nRisc
// datapath: sequencer states and the default geometry used by the datapath top.
package banco_mem_pkg;

  // LIMPA: clear sequencer running; PRONTO: normal read/write service.
  typedef enum logic {
    LIMPA  = 1'b0,
    PRONTO = 1'b1
  } estado_t;

  localparam int BM_DATA_W = 8;
  localparam int BM_ADDR_W = 8;
  localparam int BM_DEPTH  = 256;

endpackage

// File: rtl/banco_mem_param_if.sv
// Bus between the ALU/address path (master) and the memory bank (slave).
interface banco_mem_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] dado;
  logic              escreverMem;
  logic              lerMem;
  logic [DATA_W-1:0] out;
  logic              out_valido;
  logic              ocupado;
  logic              ender_invalido;
  logic              erro_paridade;

  modport master (
    output endereco, dado, escreverMem, lerMem,
    input  out, out_valido, ocupado, ender_invalido, erro_paridade
  );

  modport slave (
    input  endereco, dado, escreverMem, lerMem,
    output out, out_valido, ocupado, ender_invalido, erro_paridade
  );
endinterface

// File: rtl/banco_mem_array.sv
// Storage array: one write port, one registered read port with write-first
// bypass, and an optional per-word even-parity bit (macro BANCO_MEM_PARITY_EN).
module banco_mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              rzero_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              par_err_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bypass;

  assign bypass = we_i && (waddr_i == raddr_i);

  // Write port: word stored exactly as presented.
  always_ff @(posedge clock) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read data select: out-of-range reads give zero, same-address write wins.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      if (rzero_i)     rdata_d = '0;
      else if (bypass) rdata_d = wdata_i;
      else             rdata_d = mem[raddr_i];
    end
  end

  // Read register: holds its value when no read is requested.
  always_ff @(posedge clock) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

`ifdef BANCO_MEM_PARITY_EN
  logic par_mem [DEPTH];
  logic par_err_q, par_err_d;

  // Parity port: even parity computed on every write, including the clear.
  always_ff @(posedge clock) begin
    if (we_i) par_mem[waddr_i] <= ^wdata_i;
  end

  // Parity check only on real in-range array reads; bypassed data is fresh.
  always_comb begin
    par_err_d = 1'b0;
    if (re_i && !rzero_i && !bypass) par_err_d = (par_mem[raddr_i] != ^mem[raddr_i]);
  end

  // Parity error flag: one-cycle pulse alongside the read strobe.
  always_ff @(posedge clock) begin
    if (!reset_n) par_err_q <= 1'b0;
    else          par_err_q <= par_err_d;
  end

  assign par_err_o = par_err_q;
`else
  assign par_err_o = 1'b0;
`endif

endmodule

// File: rtl/banco_mem_param.sv
// Parametrised data-memory bank (successor of bancoMem). After reset a
// sequencer writes INIT_VAL to every word while ocupado is high; afterwards
// reads are registered (1-cycle latency, out_valido strobe), read-during-write
// is write-first and addresses >= DEPTH raise ender_invalido.
// Optional parity storage/check is enabled with macro BANCO_MEM_PARITY_EN.
module banco_mem_param
  import banco_mem_pkg::*;
#(
  parameter int                DATA_W   = BM_DATA_W,
  parameter int                ADDR_W   = BM_ADDR_W,
  parameter int                DEPTH    = BM_DEPTH,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  banco_mem_param_if.slave  bus
);

  // ptr is one bit wider so DEPTH == 2**ADDR_W still compares cleanly.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_W  = (ADDR_W+1)'(DEPTH - 1);

  estado_t           state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              ocupado_q;
  logic              out_valido_q;
  logic              ender_invalido_q;

  logic              clr_we;
  logic              pronto;
  logic              in_range;
  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;
  logic              arr_par_err;

  assign pronto   = (state_q == PRONTO);
  assign in_range = ({1'b0, bus.endereco} < DEPTH_W);

  // Next-state logic for the clear sequencer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    case (state_q)
      LIMPA: begin
        clr_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == LAST_W) state_d = PRONTO;
      end
      PRONTO: begin
        state_d = PRONTO;
      end
      default: state_d = LIMPA;
    endcase
  end

  // Array port muxing; nothing reaches the array in a reset cycle.
  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_waddr = bus.endereco;
    arr_wdata = bus.dado;
    if (reset_n) begin
      if (clr_we) begin
        arr_we    = 1'b1;
        arr_waddr = ptr_q[ADDR_W-1:0];
        arr_wdata = INIT_VAL;
      end else if (pronto) begin
        arr_we = bus.escreverMem && in_range;
        arr_re = bus.lerMem;
      end
    end
  end

  // State, pointer and status flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q          <= LIMPA;
      ptr_q            <= '0;
      ocupado_q        <= 1'b1;
      out_valido_q     <= 1'b0;
      ender_invalido_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      ocupado_q        <= (state_d == LIMPA);
      out_valido_q     <= arr_re;
      ender_invalido_q <= pronto && (bus.lerMem || bus.escreverMem) && !in_range;
    end
  end

  banco_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clock     (clock),
    .reset_n   (reset_n),
    .we_i      (arr_we),
    .waddr_i   (arr_waddr),
    .wdata_i   (arr_wdata),
    .re_i      (arr_re),
    .raddr_i   (bus.endereco),
    .rzero_i   (!in_range),
    .rdata_o   (arr_rdata),
    .par_err_o (arr_par_err)
  );

  assign bus.out            = arr_rdata;
  assign bus.out_valido     = out_valido_q;
  assign bus.ocupado        = ocupado_q;
  assign bus.ender_invalido = ender_invalido_q;
  assign bus.erro_paridade  = arr_par_err;

endmodule

// File: tb/tb_banco_mem_param.sv
// Bench for banco_mem_param: a DEPTH=256 instance (a) and a DEPTH=200
// instance (b) share clock and reset. Reads push their expected word onto a
// per-instance queue; every out_valido pops and compares.
module tb_banco_mem_param;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  banco_mem_param_if #(.DATA_W(8), .ADDR_W(8)) bus_a();
  banco_mem_param_if #(.DATA_W(8), .ADDR_W(8)) bus_b();

  banco_mem_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .INIT_VAL(8'h00)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a.slave));
  banco_mem_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .INIT_VAL(8'h00)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b.slave));

  int total = 0;
  int bad   = 0;
  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];

  typedef struct {
    logic       we;
    logic       re;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_out;
    logic       exp_valid;
  } vec_t;
  vec_t tab[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  // One request cycle on instance a (sel=0) or b (sel=1), scoreboard pop after the edge.
  task automatic cyc(input bit sel, input logic we, input logic re,
                     input logic [7:0] a, input logic [7:0] d, input logic [7:0] e);
    if (sel) begin
      bus_b.escreverMem = we; bus_b.lerMem = re; bus_b.endereco = a; bus_b.dado = d;
      if (re) sb_b.push_back(e);
    end else begin
      bus_a.escreverMem = we; bus_a.lerMem = re; bus_a.endereco = a; bus_a.dado = d;
      if (re) sb_a.push_back(e);
    end
    @(posedge clock); #1;
    if (sel) begin
      if (bus_b.out_valido) begin
        if (sb_b.size() == 0) chk("sb_b_unexpected_valid", 1, 0);
        else chk("sb_b_out", bus_b.out, sb_b.pop_front());
      end
      bus_b.escreverMem = 1'b0; bus_b.lerMem = 1'b0;
    end else begin
      if (bus_a.out_valido) begin
        if (sb_a.size() == 0) chk("sb_a_unexpected_valid", 1, 0);
        else chk("sb_a_out", bus_a.out, sb_a.pop_front());
      end
      bus_a.escreverMem = 1'b0; bus_a.lerMem = 1'b0;
    end
  endtask

  // Counts cycles with ocupado high, the reset-edge cycle counted as the first.
  task automatic count_clear(output int n);
    n = 1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clock); #1;
      if (!bus_a.ocupado) break;
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, wanted finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb, viol, idle_bad;
    bit done_b;

    tab[0]  = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1};
    tab[1]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1};
    tab[2]  = '{1'b0, 1'b1, 8'h07, 8'h00, 8'h00, 1'b1};
    tab[3]  = '{1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 1'b0};
    tab[4]  = '{1'b0, 1'b1, 8'h01, 8'h00, 8'h01, 1'b1};
    tab[5]  = '{1'b0, 1'b0, 8'h01, 8'h00, 8'h01, 1'b0};
    tab[6]  = '{1'b1, 1'b1, 8'h05, 8'hA5, 8'hA5, 1'b1};
    tab[7]  = '{1'b0, 1'b1, 8'h05, 8'h00, 8'hA5, 1'b1};
    tab[8]  = '{1'b1, 1'b0, 8'h0A, 8'h3C, 8'hA5, 1'b0};
    tab[9]  = '{1'b0, 1'b1, 8'h0A, 8'h00, 8'h3C, 1'b1};
    tab[10] = '{1'b0, 1'b0, 8'h0A, 8'h00, 8'h3C, 1'b0};
    tab[11] = '{1'b1, 1'b0, 8'hFF, 8'hFF, 8'h3C, 1'b0};
    tab[12] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'hFF, 1'b1};
    tab[13] = '{1'b1, 1'b0, 8'h05, 8'h5A, 8'hFF, 1'b0};
    tab[14] = '{1'b0, 1'b1, 8'h05, 8'h00, 8'h5A, 1'b1};

    bus_a.escreverMem = 1'b0; bus_a.lerMem = 1'b0; bus_a.endereco = '0; bus_a.dado = '0;
    bus_b.escreverMem = 1'b0; bus_b.lerMem = 1'b0; bus_b.endereco = '0; bus_b.dado = '0;

    // Reset state
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("rst_ocupado", bus_a.ocupado, 1);
    chk("rst_out", bus_a.out, 0);
    chk("rst_out_valido", bus_a.out_valido, 0);
    chk("rst_ender_invalido", bus_a.ender_invalido, 0);
    chk("rst_erro_paridade", bus_a.erro_paridade, 0);
    reset_n = 1'b1;

    // Clear window; a write+read at clear cycle 10 must be ignored
    n = 1; nb = 1; viol = 0; done_b = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (n == 10) begin
        bus_a.escreverMem = 1'b1; bus_a.lerMem = 1'b1; bus_a.endereco = 8'h07; bus_a.dado = 8'h77;
      end else begin
        bus_a.escreverMem = 1'b0; bus_a.lerMem = 1'b0;
      end
      @(posedge clock); #1;
      if (bus_a.out_valido || bus_a.ender_invalido) viol++;
      if (!done_b) begin
        if (bus_b.ocupado) nb++;
        else done_b = 1'b1;
      end
      if (!bus_a.ocupado) break;
      n++;
    end
    bus_a.escreverMem = 1'b0; bus_a.lerMem = 1'b0;
    chk("clear_cycles_a", n, 256);
    chk("clear_cycles_b", nb, 200);
    chk("clear_strobes_quiet", viol, 0);

    // Table-driven accesses on instance a
    idle_bad = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, tab[i].we, tab[i].re, tab[i].addr, tab[i].data, tab[i].exp_out);
      chk($sformatf("vec%0d_valido", i), bus_a.out_valido, tab[i].exp_valid);
      chk($sformatf("vec%0d_out", i), bus_a.out, tab[i].exp_out);
      if (bus_a.ender_invalido || bus_a.erro_paridade) idle_bad++;
    end
    chk("a_flags_quiet", idle_bad, 0);

    // Out-of-range handling on DEPTH=200 instance
    cyc(1'b1, 1'b1, 1'b0, 8'hFA, 8'h3C, 8'h00);
    chk("b_wr250_inval", bus_b.ender_invalido, 1);
    chk("b_wr250_valido", bus_b.out_valido, 0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("b_inval_pulse_ends", bus_b.ender_invalido, 0);
    cyc(1'b1, 1'b0, 1'b1, 8'hFA, 8'h00, 8'h00);
    chk("b_rd250_valido", bus_b.out_valido, 1);
    chk("b_rd250_inval", bus_b.ender_invalido, 1);
    cyc(1'b1, 1'b0, 1'b1, 8'h32, 8'h00, 8'h00);
    chk("b_rd50_inval", bus_b.ender_invalido, 0);
    cyc(1'b1, 1'b0, 1'b1, 8'h7A, 8'h00, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'hC7, 8'h3C, 8'h00);
    chk("b_wr199_inval", bus_b.ender_invalido, 0);
    cyc(1'b1, 1'b0, 1'b1, 8'hC7, 8'h00, 8'h3C);
    chk("b_rd199_valido", bus_b.out_valido, 1);
    cyc(1'b1, 1'b1, 1'b1, 8'hC8, 8'h99, 8'h00);
    chk("b_rw200_inval", bus_b.ender_invalido, 1);
    chk("b_rw200_out", bus_b.out, 0);
    cyc(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);

    // Reset on the same edge as a read cancels the strobe and zeroes out
    bus_a.lerMem = 1'b1; bus_a.endereco = 8'h05;
    reset_n = 1'b0;
    @(posedge clock); #1;
    bus_a.lerMem = 1'b0;
    chk("rst_rd_valido", bus_a.out_valido, 0);
    chk("rst_rd_out", bus_a.out, 0);
    chk("rst_rd_ocupado", bus_a.ocupado, 1);
    reset_n = 1'b1;

    // Reset again at clear cycle 100; full count must follow
    viol = 0;
    for (int i = 1; i < 100; i++) begin
      @(posedge clock); #1;
      if (!bus_a.ocupado) viol++;
    end
    chk("midclear_ocupado", viol, 0);
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("midclear_rst_ocupado", bus_a.ocupado, 1);
    reset_n = 1'b1;
    count_clear(n);
    chk("restart_clear_cycles", n, 256);

    // Contents cleared again
    cyc(1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 8'h00);
    chk("post_clear_valido", bus_a.out_valido, 1);
    cyc(1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h0A, 8'h00, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("post_clear_valido_drop", bus_a.out_valido, 0);

    chk("sb_a_drained", sb_a.size(), 0);
    chk("sb_b_drained", sb_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
